// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host controller: FSM states, frame size, timeout constant.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_pkg;

    // Host-to-device transmit sequence.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        RTS       = 3'd2,
        SEND      = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } ps2_state_t;

    // Device clock falling edges consumed in SEND: 8 data, parity, stop.
    localparam int FRAME_BITS = 10;

    // Silence on the device clock that aborts a transmit, in milliseconds.
    localparam int TIMEOUT_MS = 15;

    // PS/2 uses odd parity: data plus parity bit holds an odd number of ones.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~(^d);
    endfunction

endpackage

// File: rtl/ps2_host_ctrl_if.sv
// Bundle of every non-clock signal of ps2_host_ctrl, for benches and wrappers.
// Latency: n/a (wiring only).
// Backpressure: cmd_valid/cmd_ready handshake; receive FIFO popped with fifo_rd.
// Modports: master = host/line side that drives stimulus, slave = controller view.
interface ps2_host_ctrl_if;
    logic       ps2_clk_i;
    logic       ps2_dat_i;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_error;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       fifo_rd;
    logic [7:0] fifo_data;
    logic       fifo_empty;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_nack;
    logic       tx_timeout;
    logic       rx_overflow;
    logic       clr_status;

    modport master (
        output ps2_clk_i, ps2_dat_i, rx_data, rx_valid, rx_error,
               cmd_data, cmd_valid, fifo_rd, clr_status,
        input  ps2_clk_oe, ps2_dat_oe, cmd_ready, fifo_data, fifo_empty,
               tx_busy, tx_done, tx_nack, tx_timeout, rx_overflow
    );

    modport slave (
        input  ps2_clk_i, ps2_dat_i, rx_data, rx_valid, rx_error,
               cmd_data, cmd_valid, fifo_rd, clr_status,
        output ps2_clk_oe, ps2_dat_oe, cmd_ready, fifo_data, fifo_empty,
               tx_busy, tx_done, tx_nack, tx_timeout, rx_overflow
    );
endinterface

// File: rtl/ps2_edge_det.sv
// Synchronises a raw PS/2 line, debounces it and flags stable-high to stable-low edges.
// Latency: 11 clk from raw change to level/fall (2 sync flops + 8-sample window + output flop).
// Backpressure: none; fall is a single-cycle pulse.
// Ports: line_i raw level in; level filtered level out; fall one-cycle falling-edge pulse.
module ps2_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    output logic level,
    output logic fall
);

    logic [1:0] sync;
    logic [7:0] hist;

    // Idle PS/2 lines float high, so everything resets to the high state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= 2'b11;
            hist  <= 8'hFF;
            level <= 1'b1;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[0], line_i};
            hist <= {hist[6:0], sync[1]};
            // The level only moves when the whole window agrees; otherwise it holds.
            if (hist == 8'hFF) begin
                level <= 1'b1;
            end else if (hist == 8'h00) begin
                level <= 1'b0;
            end
            fall <= level && (hist == 8'h00);
        end
    end

endmodule

// File: rtl/ps2_host_ctrl.sv
// PS/2 host: sends one command byte to the device and buffers received bytes in a FIFO.
// Latency: cmd accepted in 1 clk; line inhibit starts next clk; received byte readable 1 clk after rx_valid.
// Backpressure: cmd_ready only in IDLE; receive bytes dropped (sticky rx_overflow) when FIFO full.
// Ports: ps2_*_i raw lines, ps2_*_oe open-drain pull-low enables, rx_* receiver byte stream,
//        cmd_* command handshake, fifo_* pop side, tx_*/rx_overflow status, clr_status clears overflow.
// Optional: define PS2_HOST_CTRL_TIMEOUT_EN to abort a transmit after 15 ms without a device clock edge.
module ps2_host_ctrl
    import ps2_pkg::*;
#(
    parameter int CLOCK_FREQ_HZ = 12000000,
    parameter int INHIBIT_US    = 100,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_error,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       fifo_rd,
    output logic [7:0] fifo_data,
    output logic       fifo_empty,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_nack,
    output logic       tx_timeout,
    output logic       rx_overflow,
    input  logic       clr_status
);

    localparam longint INH_RAW        = longint'(CLOCK_FREQ_HZ) * longint'(INHIBIT_US) / 64'd1000000;
    localparam int     INHIBIT_CYCLES = (INH_RAW < 1) ? 1 : int'(INH_RAW);
    localparam int     INH_W          = $clog2(INHIBIT_CYCLES + 1);
    localparam int     AW             = $clog2(FIFO_DEPTH);

    // ---------------- line filters ----------------
    logic clk_level, clk_fall, dat_level, dat_fall_unused;

    ps2_edge_det u_clk_det (
        .clk    (clk),
        .rst_n  (resetn),
        .line_i (ps2_clk_i),
        .level  (clk_level),
        .fall   (clk_fall)
    );

    ps2_edge_det u_dat_det (
        .clk    (clk),
        .rst_n  (resetn),
        .line_i (ps2_dat_i),
        .level  (dat_level),
        .fall   (dat_fall_unused)
    );

    // ---------------- transmit FSM ----------------
    ps2_state_t       state, state_nxt;
    logic [9:0]       tx_sh;      // remaining bits, LSB next: data, parity, stop
    logic             cur_bit;    // bit currently presented on the data line
    logic [3:0]       bit_cnt;
    logic [INH_W-1:0] inh_cnt;
    logic             started;    // holds cmd_ready low for the first clk after reset
    logic             load, shift, done_set, nack_set;

`ifdef PS2_HOST_CTRL_TIMEOUT_EN
    localparam int TO_CYCLES = int'(longint'(CLOCK_FREQ_HZ) * longint'(TIMEOUT_MS) / 64'd1000);
    localparam int TO_W      = $clog2(TO_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;
    logic            to_set, to_q;
`endif

    always_comb begin
        state_nxt  = state;
        ps2_clk_oe = 1'b0;
        ps2_dat_oe = 1'b0;
        cmd_ready  = 1'b0;
        load       = 1'b0;
        shift      = 1'b0;
        done_set   = 1'b0;
        nack_set   = 1'b0;
`ifdef PS2_HOST_CTRL_TIMEOUT_EN
        to_set     = 1'b0;
`endif
        case (state)
            IDLE: begin
                cmd_ready = started;
                if (cmd_valid && started) begin
                    load      = 1'b1;
                    state_nxt = INHIBIT;
                end
            end
            INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (inh_cnt == '0) state_nxt = RTS;
            end
            RTS: begin
                // Data goes low (start bit) while clock is still held, then clock is released.
                ps2_clk_oe = 1'b1;
                ps2_dat_oe = 1'b1;
                state_nxt  = SEND;
            end
            SEND: begin
                ps2_dat_oe = ~cur_bit;
                if (clk_fall) begin
                    shift = 1'b1;
                    if (bit_cnt == 4'(FRAME_BITS - 1)) state_nxt = ACK;
                end
            end
            ACK: begin
                if (clk_fall) begin
                    done_set  = ~dat_level;
                    nack_set  = dat_level;
                    state_nxt = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (clk_level && dat_level) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
`ifdef PS2_HOST_CTRL_TIMEOUT_EN
        // A device edge in the same cycle as expiry still counts as progress.
        if ((state == RTS || state == SEND || state == ACK) && !clk_fall &&
            (to_cnt == TO_W'(TO_CYCLES - 1))) begin
            to_set    = 1'b1;
            state_nxt = WAIT_IDLE;
        end
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            tx_sh    <= '0;
            cur_bit  <= 1'b1;
            bit_cnt  <= '0;
            inh_cnt  <= '0;
            started  <= 1'b0;
            tx_done  <= 1'b0;
            tx_nack  <= 1'b0;
        end else begin
            state   <= state_nxt;
            started <= 1'b1;
            tx_done <= done_set;
            tx_nack <= nack_set;
            if (load) begin
                tx_sh   <= {1'b1, odd_parity(cmd_data), cmd_data};
                cur_bit <= 1'b0;
                bit_cnt <= '0;
                inh_cnt <= INH_W'(INHIBIT_CYCLES - 1);
            end else begin
                if (state == INHIBIT && inh_cnt != '0) inh_cnt <= inh_cnt - 1'b1;
                if (shift) begin
                    cur_bit <= tx_sh[0];
                    tx_sh   <= {1'b1, tx_sh[9:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

`ifdef PS2_HOST_CTRL_TIMEOUT_EN
    // Counts cycles since RTS or since the last device clock edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            to_cnt <= '0;
            to_q   <= 1'b0;
        end else begin
            to_q <= to_set;
            if ((state == RTS || state == SEND || state == ACK) && !clk_fall &&
                (to_cnt != TO_W'(TO_CYCLES - 1))) begin
                to_cnt <= to_cnt + 1'b1;
            end else begin
                to_cnt <= '0;
            end
        end
    end
    assign tx_timeout = to_q;
`else
    assign tx_timeout = 1'b0;
`endif

    assign tx_busy = (state != IDLE);

    // ---------------- receive FIFO ----------------
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic [7:0]  hold_q;
    logic        full, push_req, push, pop, ovf_evt;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // Bytes arriving during a transmit are our own frame echoed back by the receiver.
    assign push_req   = (state == IDLE) && rx_valid && !rx_error;
    assign pop        = fifo_rd && !fifo_empty;
    assign push       = push_req && (!full || pop);
    assign ovf_evt    = push_req && full && !pop;
    assign fifo_data  = fifo_empty ? hold_q : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= rx_data;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            hold_q      <= '0;
            rx_overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                hold_q <= mem[rd_ptr[AW-1:0]];
            end
            if (ovf_evt) begin
                rx_overflow <= 1'b1;
            end else if (clr_status) begin
                rx_overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_ctrl.sv
module tb_ps2_host_ctrl;
    import ps2_pkg::*;

    localparam int HALF = 30;       // device clock half period in system clocks

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic dev_clk = 1'b1;
    logic dev_dat = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic timeout_seen = 1'b0;

    always #5 clk = ~clk;

    ps2_host_ctrl_if bus ();

    // Open-drain bus: either side may pull low.
    assign bus.ps2_clk_i = dev_clk & ~bus.ps2_clk_oe;
    assign bus.ps2_dat_i = dev_dat & ~bus.ps2_dat_oe;

    ps2_host_ctrl #(
        .CLOCK_FREQ_HZ (12000000),
        .INHIBIT_US    (100),
        .FIFO_DEPTH    (8)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .ps2_clk_i   (bus.ps2_clk_i),
        .ps2_dat_i   (bus.ps2_dat_i),
        .ps2_clk_oe  (bus.ps2_clk_oe),
        .ps2_dat_oe  (bus.ps2_dat_oe),
        .rx_data     (bus.rx_data),
        .rx_valid    (bus.rx_valid),
        .rx_error    (bus.rx_error),
        .cmd_data    (bus.cmd_data),
        .cmd_valid   (bus.cmd_valid),
        .cmd_ready   (bus.cmd_ready),
        .fifo_rd     (bus.fifo_rd),
        .fifo_data   (bus.fifo_data),
        .fifo_empty  (bus.fifo_empty),
        .tx_busy     (bus.tx_busy),
        .tx_done     (bus.tx_done),
        .tx_nack     (bus.tx_nack),
        .tx_timeout  (bus.tx_timeout),
        .rx_overflow (bus.rx_overflow),
        .clr_status  (bus.clr_status)
    );

    always @(negedge clk) if (bus.tx_timeout === 1'b1) timeout_seen = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Handshake a command, measure the inhibit window, check RTS and the start bit.
    task automatic start_cmd(input logic [7:0] c);
        int inh;
        @(negedge clk);
        chk("cmd_ready_idle", bus.cmd_ready, 1);
        bus.cmd_data  = c;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("cmd_ready_busy", bus.cmd_ready, 0);
        inh = 0;
        while (bus.ps2_clk_oe && !bus.ps2_dat_oe && inh < 5000) begin
            inh++;
            @(negedge clk);
        end
        chk("inhibit_len", inh, 1200);
        chk("rts_clk_oe", bus.ps2_clk_oe, 1);
        chk("rts_dat_oe", bus.ps2_dat_oe, 1);
        @(negedge clk);
        chk("send_clk_released", bus.ps2_clk_oe, 0);
        chk("start_bit_low", bus.ps2_dat_oe, 1);
    endtask

    // Device generates n clock pulses and samples the line late in each low phase.
    task automatic clock_bits(input logic [9:0] frame, input int n);
        logic [9:0] f;
        f = frame;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            chk($sformatf("bit%0d", i), bus.ps2_dat_i, f[i]);
            chk("busy_in_frame", bus.tx_busy, 1);
            dev_clk = 1'b1;
            repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic finish_ack(input bit ack_low, input int exp_done, input int exp_nack);
        int nd, nn, k;
        chk("dat_released_after_stop", bus.ps2_dat_oe, 0);
        dev_dat = ack_low ? 1'b0 : 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk = 1'b0;
        nd = 0;
        nn = 0;
        repeat (2 * HALF) begin
            @(negedge clk);
            if (bus.tx_done === 1'b1) nd++;
            if (bus.tx_nack === 1'b1) nn++;
        end
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        k = 0;
        while (bus.tx_busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("tx_done_cycles", nd, exp_done);
        chk("tx_nack_cycles", nn, exp_nack);
        chk("idle_after_frame", bus.tx_busy, 0);
    endtask

    task automatic push(input logic [7:0] d, input logic err, input logic rd, input logic clr);
        @(negedge clk);
        bus.rx_data    = d;
        bus.rx_valid   = 1'b1;
        bus.rx_error   = err;
        bus.fifo_rd    = rd;
        bus.clr_status = clr;
        @(negedge clk);
        bus.rx_valid   = 1'b0;
        bus.rx_error   = 1'b0;
        bus.fifo_rd    = 1'b0;
        bus.clr_status = 1'b0;
    endtask

    initial begin
        int n;
        bus.rx_data = 8'h00; bus.rx_valid = 1'b0; bus.rx_error = 1'b0;
        bus.cmd_data = 8'h00; bus.cmd_valid = 1'b0;
        bus.fifo_rd = 1'b0; bus.clr_status = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_clk_oe", bus.ps2_clk_oe, 0);
        chk("rst_dat_oe", bus.ps2_dat_oe, 0);
        chk("rst_cmd_ready", bus.cmd_ready, 0);
        chk("rst_fifo_empty", bus.fifo_empty, 1);
        chk("rst_status", {bus.tx_busy, bus.tx_done, bus.tx_nack, bus.tx_timeout, bus.rx_overflow}, 0);
        resetn = 1'b1;
        #1;
        chk("cmd_ready_before_first_clk", bus.cmd_ready, 0);
        @(negedge clk);
        chk("cmd_ready_after_first_clk", bus.cmd_ready, 1);

`ifdef PS2_HOST_CTRL_TIMEOUT_EN
        // Silent device: abort 180000 cycles after RTS with lines released.
        start_cmd(8'h5A);
        n = 1;
        while (!bus.tx_timeout && n < 200000) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycles", n, 180000);
        chk("timeout_clk_rel", bus.ps2_clk_oe, 0);
        chk("timeout_dat_rel", bus.ps2_dat_oe, 0);
        @(negedge clk);
        chk("timeout_pulse_width", bus.tx_timeout, 0);
        repeat (40) @(negedge clk);
        chk("timeout_idle", bus.tx_busy, 0);
`endif

        // 0xFF with device ACK: bits 1x8, parity 1, stop 1
        start_cmd(8'hFF);
        clock_bits(10'h3FF, 10);
        finish_ack(1'b1, 1, 0);

        // 0xED with NACK, plus a receive byte during the frame that must be dropped
        start_cmd(8'hED);
        @(negedge clk);
        bus.rx_data = 8'hAA;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        clock_bits(10'h3ED, 10);
        finish_ack(1'b0, 0, 1);
        chk("rx_during_tx_dropped", bus.fifo_empty, 1);

        // rx_error alone pushes nothing; read on empty is ignored
        push(8'h77, 1'b1, 1'b0, 1'b0);
        chk("rx_error_no_push", bus.fifo_empty, 1);
        @(negedge clk);
        bus.fifo_rd = 1'b1;
        @(negedge clk);
        bus.fifo_rd = 1'b0;
        chk("rd_empty_ignored", bus.fifo_empty, 1);

        // Nine bytes into eight entries: last is dropped, overflow sticks
        for (int i = 1; i <= 9; i++) begin
            push(8'(i), 1'b0, 1'b0, 1'b0);
            if (i == 8) chk("no_ovf_at_full", bus.rx_overflow, 0);
        end
        chk("ovf_set", bus.rx_overflow, 1);
        chk("fifo_not_empty", bus.fifo_empty, 0);
        @(negedge clk);
        bus.clr_status = 1'b1;
        @(negedge clk);
        bus.clr_status = 1'b0;
        chk("ovf_cleared", bus.rx_overflow, 0);
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("fifo_rd%0d", i), bus.fifo_data, 8'(i));
            bus.fifo_rd = 1'b1;
            @(negedge clk);
            bus.fifo_rd = 1'b0;
        end
        chk("fifo_drained", bus.fifo_empty, 1);
        chk("fifo_data_hold", bus.fifo_data, 8'h08);

        // Push with pop while full succeeds
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i), 1'b0, 1'b0, 1'b0);
        push(8'h18, 1'b0, 1'b1, 1'b0);
        chk("push_pop_full_no_ovf", bus.rx_overflow, 0);
        chk("push_pop_full_head", bus.fifo_data, 8'h11);
        // Overflow and clear in the same cycle: overflow wins
        push(8'h19, 1'b0, 1'b0, 1'b1);
        chk("ovf_beats_clr", bus.rx_overflow, 1);

        // Reset while presenting bit 4 of 0x00
        start_cmd(8'h00);
        clock_bits(10'h300, 4);
        dev_clk = 1'b0;
        repeat (20) @(negedge clk);
        chk("bit4_driven", bus.ps2_dat_oe, 1);
        #2 resetn = 1'b0;
        #1;
        chk("rst_mid_clk_oe", bus.ps2_clk_oe, 0);
        chk("rst_mid_dat_oe", bus.ps2_dat_oe, 0);
        dev_clk = 1'b1;
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mid_idle", bus.tx_busy, 0);
        chk("rst_mid_ready", bus.cmd_ready, 1);
        chk("rst_mid_fifo_empty", bus.fifo_empty, 1);
        chk("rst_mid_ovf", bus.rx_overflow, 0);
        repeat (20) @(negedge clk);
        chk("rst_mid_lines_idle", {bus.ps2_clk_oe, bus.ps2_dat_oe}, 0);

`ifndef PS2_HOST_CTRL_TIMEOUT_EN
        chk("timeout_tied_low", timeout_seen, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_host_ctrl.md
PS2_HOST_CTRL -- requirements
Module: ps2_host_ctrl

Interface
REQ-001 SHALL have parameter CLOCK_FREQ_HZ, default 12000000, system clock frequency in Hz.
REQ-002 SHALL have parameter INHIBIT_US, default 100, clock-inhibit time before a host-to-device frame.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8 (power of two), receive FIFO entries.
REQ-004 SHALL have port clk  in  1  system clock; single clock domain.
REQ-005 SHALL have port resetn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports ps2_clk_i, ps2_dat_i  in  1 each  raw PS/2 line levels.
REQ-007 SHALL have ports ps2_clk_oe, ps2_dat_oe  out  1 each  1 = drive line low (open-drain).
REQ-008 SHALL have ports rx_data  in  8, rx_valid  in  1, rx_error  in  1  byte stream from the PS/2 receiver.
REQ-009 SHALL have ports cmd_data  in  8, cmd_valid  in  1, cmd_ready  out  1  host command, valid/ready handshake.
REQ-010 SHALL have ports fifo_rd  in  1, fifo_data  out  8, fifo_empty  out  1  receive FIFO pop side.
REQ-011 SHALL have ports tx_busy, tx_done, tx_nack, tx_timeout, rx_overflow, clr_status: out 1 each, except clr_status in 1.

Function
REQ-012 SHALL run FSM IDLE -> INHIBIT -> RTS -> SEND -> ACK -> WAIT_IDLE -> IDLE.
REQ-013 SHALL assert cmd_ready only in IDLE; cmd_valid&&cmd_ready latches cmd_data and enters INHIBIT next cycle.
REQ-014 SHALL in INHIBIT drive ps2_clk_oe=1 for exactly CLOCK_FREQ_HZ*INHIBIT_US/1000000 cycles (integer division, minimum 1).
REQ-015 SHALL in RTS drive ps2_dat_oe=1 one cycle before releasing ps2_clk_oe, then enter SEND.
REQ-016 SHALL in SEND, on each filtered device falling clk edge, present next bit: data[0..7] LSB first, odd parity, stop (dat released); 10 edges total.
REQ-017 SHALL in ACK sample dat on next falling edge: low = success (tx_done pulse 1 cycle), high = tx_nack pulse 1 cycle.
REQ-018 SHALL in WAIT_IDLE remain until filtered clk and dat both high, then return to IDLE.
REQ-019 SHALL hold tx_busy=1 in every state except IDLE.
REQ-020 SHALL discard rx_valid and rx_error while tx_busy=1 (receiver sees host frame).
REQ-021 SHALL in IDLE push rx_data on rx_valid; rx_error pushes nothing.
REQ-022 SHALL on push when full drop the new byte and set sticky rx_overflow; simultaneous push and pop when full SHALL succeed (no overflow).
REQ-023 SHALL ignore fifo_rd when fifo_empty; fifo_data shows head entry combinationally, undefined-free (holds last value) when empty.
REQ-024 SHALL clear rx_overflow on clr_status; a same-cycle overflow event wins.
REQ-025 SHALL filter ps2_clk_i with 2-flop sync plus 8-sample stable filter; edge = stable-high to stable-low.

Reset
REQ-026 SHALL on resetn low: FSM IDLE, ps2_clk_oe=0, ps2_dat_oe=0, cmd_ready=0 until first clk after release, FIFO empty, all status outputs 0, filter state high.
REQ-027 SHALL, on reset mid-frame, release both lines immediately (asynchronous) and lose the command.

Configuration
REQ-028 SHALL with PS2_HOST_CTRL_TIMEOUT_EN defined, abort from RTS/SEND/ACK if no falling edge for 15 ms (CLOCK_FREQ_HZ*15/1000 cycles): release lines, pulse tx_timeout 1 cycle, go to WAIT_IDLE.
REQ-029 SHALL without PS2_HOST_CTRL_TIMEOUT_EN wait indefinitely; tx_timeout tied 0.

Structure
REQ-030 SHALL place FSM state enum, frame bit count (10) and timeout-ms constant in shared package ps2_pkg.
REQ-031 SHALL implement sync/filter/edge detect as sub-module ps2_edge_det, one instance for clk line, one for dat level.

Verification
REQ-032 SHALL cover: cmd 0xFF at 12 MHz -> ps2_clk_oe low 1200 cycles, bits 1,1,1,1,1,1,1,1, parity 1, stop, device ACK -> tx_done pulse.
REQ-033 SHALL cover: cmd 0xED, device holds dat high at ACK -> tx_nack pulse, no tx_done, return to IDLE.
REQ-034 SHALL cover: 9 rx_valid bytes 0x01..0x09, no reads -> FIFO holds 0x01..0x08, rx_overflow=1; clr_status -> 0.
REQ-035 SHALL cover: rx_valid 0xAA during tx_busy -> FIFO stays empty.
REQ-036 SHALL cover: TIMEOUT_EN, device silent after RTS -> tx_timeout after 180000 cycles at 12 MHz, lines released.
REQ-037 SHALL cover: resetn low during SEND bit 4 -> both oe outputs 0 same cycle, FSM IDLE after release.
